imem_loader: RTL and testbench

- Program-load front end for the 9-bit-instruction core. It accepts a framed byte stream over a valid/ready interface and assembles it into instruction words.
- It writes those words into the instruction RAM through a simple write port. This is the writer side of the memory the core's fetch path reads.
- It holds the core in reset until a complete, well-formed program has been written, then releases it.

---
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader.sv | 150 +++++++++++++++
 tb/tb_imem_loader.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Loader bus: inbound byte stream (valid/ready) plus instruction-RAM write port.
// slave is the loader side; master is the stream source / RAM observer side.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned INST_W = 9
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_wdata;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Program-load front end: parses HEADER, LEN, {LO, HI} x LEN from a byte stream,
// writes each assembled word into the instruction RAM and holds the core in
// reset until a complete frame has landed.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       INST_W    = 9,
    parameter logic [7:0]        HEADER    = 8'hA5,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic           clk,
    input  logic           rst,
    imem_loader_if.slave   bus,
    output logic           cpu_rst_hold,
    output logic           load_done,
    output logic           load_err
);
    // Number of HI-byte bits that land in the instruction word.
    localparam int unsigned HiW = INST_W - 8;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StLo,
        StHi,
        StCsum,
        StDone,
        StErr
    } state_t;

    state_t     state;
    logic [7:0] len;
    logic [7:0] cnt;
    logic [7:0] lo;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
`endif

    logic fire;
    logic hi_bad;
    logic last_word;

    // Handshake, illegal HI bits, and final-word detection.
    always_comb begin
        fire      = bus.in_valid & bus.in_ready;
        hi_bad    = (bus.in_data >> HiW) != 8'd0;
        last_word = (cnt + 8'd1) == len;
    end

    // Frame-parsing FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= StIdle;
            len            <= 8'd0;
            cnt            <= 8'd0;
            lo             <= 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum           <= 8'd0;
`endif
            bus.in_ready   <= 1'b1;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= BASE_ADDR;
            bus.imem_wdata <= '0;
            cpu_rst_hold   <= 1'b1;
            load_done      <= 1'b0;
            load_err       <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (fire && bus.in_data == HEADER) begin
                        state <= StLen;
                    end
                end
                StLen: begin
                    if (fire) begin
                        if (bus.in_data == 8'd0) begin
                            state    <= StErr;
                            load_err <= 1'b1;
                        end else begin
                            len   <= bus.in_data;
                            cnt   <= 8'd0;
                            state <= StLo;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum  <= bus.in_data;
`endif
                        end
                    end
                end
                StLo: begin
                    if (fire) begin
                        lo    <= bus.in_data;
                        state <= StHi;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum  <= csum + bus.in_data;
`endif
                    end
                end
                StHi: begin
                    if (fire) begin
                        if (hi_bad) begin
                            state    <= StErr;
                            load_err <= 1'b1;
                        end else begin
                            bus.imem_we    <= 1'b1;
                            bus.imem_addr  <= BASE_ADDR + ADDR_W'(cnt);
                            bus.imem_wdata <= {bus.in_data[HiW-1:0], lo};
                            cnt            <= cnt + 8'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum           <= csum + bus.in_data;
                            state          <= last_word ? StCsum : StLo;
`else
                            state          <= last_word ? StDone : StLo;
`endif
                        end
                    end
                end
                StCsum: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (fire) begin
                        if (bus.in_data == csum) begin
                            state <= StDone;
                        end else begin
                            state    <= StErr;
                            load_err <= 1'b1;
                        end
                    end
`else
                    state <= StIdle;
`endif
                end
                StDone: begin
                    // Terminal until rst: stop accepting and release the core.
                    bus.in_ready <= 1'b0;
                    load_done    <= 1'b1;
                    cpu_rst_hold <= 1'b0;
                end
                StErr: begin
                    cpu_rst_hold <= 1'b1;
                    bus.in_ready <= 1'b1;
                    if (fire && bus.in_data == HEADER) begin
                        load_err <= 1'b0;
                        state    <= StLen;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: one DUT at BASE_ADDR 0, one at 8'hFE for wrap.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(8), .INST_W(9)) bus0 ();
    imem_loader_if #(.ADDR_W(8), .INST_W(9)) bus1 ();

    logic [7:0] drv_data  = 8'h00;
    logic       drv_valid = 1'b0;
    logic       sel       = 1'b0;

    assign bus0.in_data  = drv_data;
    assign bus0.in_valid = drv_valid & ~sel;
    assign bus1.in_data  = drv_data;
    assign bus1.in_valid = drv_valid & sel;

    logic hold0, done0, err0, hold1, done1, err1;

    imem_loader #(.ADDR_W(8), .INST_W(9), .HEADER(8'hA5), .BASE_ADDR(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus0.slave),
        .cpu_rst_hold (hold0),
        .load_done    (done0),
        .load_err     (err0)
    );

    imem_loader #(.ADDR_W(8), .INST_W(9), .HEADER(8'hA5), .BASE_ADDR(8'hFE)) dut_w (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus1.slave),
        .cpu_rst_hold (hold1),
        .load_done    (done1),
        .load_err     (err1)
    );

    // Outputs of whichever DUT is currently selected.
    logic       rdy_s, we_s, hold_s, done_s, err_s;
    logic [7:0] addr_s;
    logic [8:0] wdata_s;
    assign rdy_s   = sel ? bus1.in_ready   : bus0.in_ready;
    assign we_s    = sel ? bus1.imem_we    : bus0.imem_we;
    assign addr_s  = sel ? bus1.imem_addr  : bus0.imem_addr;
    assign wdata_s = sel ? bus1.imem_wdata : bus0.imem_wdata;
    assign hold_s  = sel ? hold1 : hold0;
    assign done_s  = sel ? done1 : done0;
    assign err_s   = sel ? err1  : err0;

    int n_checks = 0;
    int n_errs   = 0;
    int wcnt     = 0;

    always @(negedge clk) if (we_s) wcnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        drv_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        rst = 1'b0;
    endtask

    task automatic check_reset(input logic [7:0] base);
        check("rst_ready", rdy_s, 1);
        check("rst_we", we_s, 0);
        check("rst_addr", addr_s, base);
        check("rst_wdata", wdata_s, 0);
        check("rst_hold", hold_s, 1);
        check("rst_done", done_s, 0);
        check("rst_err", err_s, 0);
    endtask

    // Present one byte (optionally after a valid-low gap) and wait for its handshake.
    task automatic send(input logic [7:0] b, input bit gap);
        int n;
        if (gap) begin
            drv_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        drv_data  = b;
        drv_valid = 1'b1;
        n = 0;
        while (!rdy_s && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy_s) begin
            check("ready_timeout", 0, 1);
        end else begin
            @(posedge clk);
            #1;
        end
        drv_valid = 1'b0;
    endtask

    task automatic pair(input logic [7:0] lo, input logic [7:0] hi, input bit gap,
                        input logic [7:0] exp_addr, input logic [8:0] exp_data);
        send(lo, gap);
        send(hi, gap);
        check("wr_we", we_s, 1);
        check("wr_addr", addr_s, exp_addr);
        check("wr_data", wdata_s, exp_data);
    endtask

    // Optional checksum byte, then load_done/cpu_rst_hold one cycle later.
    task automatic finish_frame(input logic [7:0] csum, input bit gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(csum, gap);
`else
        if (gap && csum == 8'hxx) $display("unreachable");
`endif
        check("pre_done", done_s, 0);
        @(posedge clk);
        #1;
        check("done", done_s, 1);
        check("hold_released", hold_s, 0);
        check("ready_low", rdy_s, 0);
        check("done_err", err_s, 0);
    endtask

    int w0;

    initial begin
        // Reset state
        sel = 1'b0;
        do_reset();
        check_reset(8'h00);
        release_reset();

        // Basic load at full rate
        w0 = wcnt;
        send(8'hA5, 0);
        send(8'h03, 0);
        pair(8'h01, 8'h00, 0, 8'h00, 9'h001);
        pair(8'hFF, 8'h01, 0, 8'h01, 9'h1FF);
        pair(8'h34, 8'h00, 0, 8'h02, 9'h034);
        check("last_hold", hold_s, 1);
        finish_frame(8'h38, 0);
        check("basic_wcount", wcnt - w0, 3);

        // Same frame with valid toggled every other cycle
        do_reset();
        release_reset();
        w0 = wcnt;
        send(8'hA5, 1);
        send(8'h03, 1);
        pair(8'h01, 8'h00, 1, 8'h00, 9'h001);
        pair(8'hFF, 8'h01, 1, 8'h01, 9'h1FF);
        pair(8'h34, 8'h00, 1, 8'h02, 9'h034);
        finish_frame(8'h38, 1);
        check("gap_wcount", wcnt - w0, 3);
        // Bytes offered in DONE are ignored
        drv_data  = 8'hA5;
        drv_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        drv_valid = 1'b0;
        check("done_ready", rdy_s, 0);
        check("done_sticky", done_s, 1);
        check("done_nowrite", wcnt - w0, 3);

        // Errors: LEN=0, illegal HI, recovery
        do_reset();
        release_reset();
        w0 = wcnt;
        send(8'hA5, 0);
        send(8'h00, 0);
        check("len0_err", err_s, 1);
        check("len0_hold", hold_s, 1);
        send(8'hA5, 0);
        check("hdr_clears_err", err_s, 0);
        send(8'h01, 0);
        send(8'h05, 0);
        send(8'h02, 0);
        check("hi_err", err_s, 1);
        check("hi_no_we", we_s, 0);
        check("err_nowrite", wcnt - w0, 0);
        send(8'h13, 0);
        check("err_junk", err_s, 1);
        send(8'hA5, 0);
        check("recover_err", err_s, 0);
        send(8'h01, 0);
        pair(8'h07, 8'h00, 0, 8'h00, 9'h007);
        finish_frame(8'h08, 0);

        // Leading junk, then reset mid-frame
        do_reset();
        release_reset();
        w0 = wcnt;
        send(8'h00, 0);
        send(8'h13, 0);
        check("junk_nowrite", wcnt - w0, 0);
        check("junk_err", err_s, 0);
        send(8'hA5, 0);
        send(8'h03, 0);
        pair(8'h11, 8'h00, 0, 8'h00, 9'h011);
        pair(8'h22, 8'h01, 0, 8'h01, 9'h122);
        send(8'h33, 0);
        do_reset();
        check_reset(8'h00);
        release_reset();
        send(8'hA5, 0);
        send(8'h02, 0);
        pair(8'hAA, 8'h01, 0, 8'h00, 9'h1AA);
        pair(8'h55, 8'h00, 0, 8'h01, 9'h055);
        finish_frame(8'h02, 0);

        // Address wrap with BASE_ADDR = 8'hFE
        sel = 1'b1;
        do_reset();
        check_reset(8'hFE);
        release_reset();
        send(8'hA5, 0);
        send(8'h03, 0);
        pair(8'h01, 8'h00, 0, 8'hFE, 9'h001);
        pair(8'h02, 8'h00, 0, 8'hFF, 9'h002);
        pair(8'h03, 8'h01, 0, 8'h00, 9'h103);
        finish_frame(8'h0A, 0);
        sel = 1'b0;

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        do_reset();
        release_reset();
        send(8'hA5, 0);
        send(8'h02, 0);
        pair(8'h10, 8'h00, 0, 8'h00, 9'h010);
        pair(8'h20, 8'h01, 0, 8'h01, 9'h120);
        finish_frame(8'h33, 0);

        do_reset();
        release_reset();
        send(8'hA5, 0);
        send(8'h02, 0);
        pair(8'h10, 8'h00, 0, 8'h00, 9'h010);
        pair(8'h20, 8'h01, 0, 8'h01, 9'h120);
        send(8'h34, 0);
        check("csum_err", err_s, 1);
        @(posedge clk);
        #1;
        check("csum_hold", hold_s, 1);
        check("csum_not_done", done_s, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
